frame_scheduler: RTL and testbench
==================================

# frame_scheduler

Sequences the fingerprint datapath one analysis frame at a time: holds `shazam_core` in reset between frames, releases it, waits for its maxima, and loads the PISO only when the dual-clock FIFO can accept the frame. It sits between `shazam_core`/`PISO` and the FIFO write port. It prefixes each frame with a header word so the SPI receiver can resynchronise. It keeps saturating frame, drop and timeout statistics.

## Interface
- `PEAKS`, 16: frequency words per frame streamed by the PISO.
- `DSIZE`, 9: FIFO word width.
- `TIMEOUT_CYCLES`, 2_000_000: maximum `clk` cycles spent waiting in WAIT_PEAKS or STREAM.
- `HEADER_WORD`, 9'h1FF: frame marker written before the peaks.
- `clk` in 1: system clock (50 MHz); the only clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: run enable, level.
- `maximas_found_active` in 1: one-cycle pulse from core; maxima valid this cycle only.
- `piso_serial_out` in DSIZE: PISO output word.
- `piso_output_active` in 1: PISO word valid.
- `fifo_full` in 1: FIFO `wfull`.
- `core_reset` out 1: reset to `shazam_core`.
- `piso_load` out 1: load strobe to PISO.
- `fifo_winc` out 1: FIFO write enable.
- `fifo_wdata` out DSIZE: FIFO write data.
- `busy` out 1: high in any state except IDLE.
- `frame_count` out 16: frames fully streamed, saturating.
- `drop_count` out 8: frames discarded because the FIFO was full at decision time, saturating.
- `timeout_count` out 8: WAIT_PEAKS or STREAM timeouts, saturating.

## Operation
- States:
  - IDLE: `core_reset`=1. Go to REARM when `start`=1.
  - REARM: one cycle with `core_reset`=1, then go to WAIT_PEAKS.
  - WAIT_PEAKS: `core_reset`=0; the timeout counter runs.
  - STREAM: forwards PISO words to the FIFO.
- WAIT_PEAKS, `maximas_found_active`=1 and `fifo_full`=0, in the same cycle:
  - `piso_load`=1.
  - `fifo_winc`=1 with `fifo_wdata`=HEADER_WORD.
  - Next state STREAM; word counter cleared.
- WAIT_PEAKS, `maximas_found_active`=1 and `fifo_full`=1: no load, no write, `drop_count`++, go to REARM.
- WAIT_PEAKS, `start`=0: go to IDLE immediately; a same-cycle `maximas_found_active` is ignored.
- STREAM:
  - `fifo_winc`=`piso_output_active`, `fifo_wdata`=`piso_serial_out`; the word counter increments per active cycle.
  - After word PEAKS: `frame_count`++, then REARM if `start`=1, else IDLE.
  - `start` falling mid-stream does not abort the frame.
- `fifo_full` during STREAM: the write is still issued and the FIFO discards it. No extra handling; the frame still counts.
- Timeout: the counter reaches TIMEOUT_CYCLES in WAIT_PEAKS or STREAM → `timeout_count`++, go to REARM (IDLE if `start`=0).
- The timeout counter clears on every state entry.
- All counters saturate at their all-ones value and never wrap.

## Timing
- Reset values:
  - `core_reset`=1; `piso_load`=0; `fifo_winc`=0; `fifo_wdata`=0; `busy`=0.
  - All counts 0; state IDLE.
- Reset mid-operation returns everything to these values at the next `clk` edge. A frame partially written to the FIFO is not retracted.
- `piso_load` and the header `fifo_winc` are combinational from `maximas_found_active`, `fifo_full` and state: zero-cycle latency, because maxima are valid only in the pulse cycle.
- In STREAM, `fifo_winc`/`fifo_wdata` are combinational pass-through of the PISO outputs: 0 latency.
- `core_reset` and `busy` are registered state decodes.
- Minimum core reset between frames: 1 cycle (REARM). From IDLE, `start` to first core release: 2 cycles.
- Counter increments are visible the cycle after the triggering event.

## Structure
- Package `shazam_sched_pkg`: state enum (IDLE, REARM, WAIT_PEAKS, STREAM) and default HEADER_WORD.
- Sub-module `sat_counter` (parameter WIDTH; ports `clk`, `reset`, `inc`, `count`): instantiated three times for the statistics.
- Word counter and timeout counter live in the FSM body.

## Test plan
- `start`=1, core pulses `maximas_found_active` with `fifo_full`=0, then PISO gives 16 words 1..16 → FIFO receives 0x1FF,1..16; `frame_count`=1; `core_reset` high exactly 1 cycle, then low.
- `fifo_full`=1 at the maxima pulse → `piso_load`=0, no writes, `drop_count`=1, REARM follows.
- No maxima pulse for TIMEOUT_CYCLES (set to 100) → `timeout_count`=1 at cycle 101 of WAIT_PEAKS; PISO stalls after 5 words → second timeout.
- `start` dropped after word 8 → frame completes to 16 words, then IDLE with `core_reset`=1; `start` dropped in WAIT_PEAKS → IDLE next cycle.
- Force 256 drops → `drop_count` holds 255; `reset` asserted mid-STREAM → all outputs at reset values next edge.

Source files
------------

// File: rtl/shazam_sched_pkg.sv
// Package shared by the frame scheduler files.
//   sched_state_t       : the scheduler FSM states.
//   DEFAULT_HEADER_WORD : frame marker that precedes each frame in the FIFO,
//                         used so the SPI receiver can resynchronise.
package shazam_sched_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    REARM      = 2'd1,
    WAIT_PEAKS = 2'd2,
    STREAM     = 2'd3
  } sched_state_t;

  localparam logic [8:0] DEFAULT_HEADER_WORD = 9'h1FF;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses and holds at all-ones.
//   clk   : system clock
//   reset : synchronous, active-high; clears the count
//   inc   : count one event this cycle
//   count : current count, updated the cycle after inc
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (inc && !(&count_reg)) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/frame_scheduler.sv
// Frame scheduler: runs the fingerprint datapath one analysis frame at a
// time. Holds shazam_core in reset between frames, waits for its maxima
// pulse, then either loads the PISO (writing a header word to the FIFO) or
// drops the frame when the FIFO is full. In STREAM the PISO words are passed
// straight through to the FIFO write port.
//   clk, reset            : system clock, synchronous active-high reset
//   start                 : run enable (level)
//   maximas_found_active  : one-cycle maxima pulse from the core
//   piso_serial_out/_active : PISO word and its valid
//   fifo_full             : FIFO wfull
//   core_reset            : reset to shazam_core (registered)
//   piso_load             : PISO load strobe (combinational)
//   fifo_winc/fifo_wdata  : FIFO write port (combinational)
//   busy                  : high whenever not IDLE (registered)
//   frame_count/drop_count/timeout_count : saturating statistics
module frame_scheduler
  import shazam_sched_pkg::*;
#(
  parameter int               PEAKS          = 16,
  parameter int               DSIZE          = 9,
  parameter int               TIMEOUT_CYCLES = 2_000_000,
  parameter logic [DSIZE-1:0] HEADER_WORD    = DSIZE'(DEFAULT_HEADER_WORD)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             maximas_found_active,
  input  logic [DSIZE-1:0] piso_serial_out,
  input  logic             piso_output_active,
  input  logic             fifo_full,
  output logic             core_reset,
  output logic             piso_load,
  output logic             fifo_winc,
  output logic [DSIZE-1:0] fifo_wdata,
  output logic             busy,
  output logic [15:0]      frame_count,
  output logic [7:0]       drop_count,
  output logic [7:0]       timeout_count
);

  localparam int WORD_W  = $clog2(PEAKS + 1);
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

  sched_state_t       state_reg;
  logic               core_reset_reg;
  logic               busy_reg;
  logic [WORD_W-1:0]  word_cnt_reg;
  logic [TIMER_W-1:0] timer_reg;

  logic wait_st, stream_st, timer_hit;
  logic hdr_write, drop_evt, frame_done, timeout_evt;

  // Event decode. The maxima are only valid in their pulse cycle, so the
  // load/header decision must be combinational. A falling start in
  // WAIT_PEAKS overrides any same-cycle maxima pulse.
  always_comb begin
    wait_st     = (state_reg == WAIT_PEAKS);
    stream_st   = (state_reg == STREAM);
    // The timer holds cycles already spent in the state, so this is the
    // last permitted cycle.
    timer_hit   = (timer_reg == TIMER_W'(TIMEOUT_CYCLES - 1));
    hdr_write   = wait_st && start && maximas_found_active && !fifo_full;
    drop_evt    = wait_st && start && maximas_found_active && fifo_full;
    frame_done  = stream_st && piso_output_active &&
                  (word_cnt_reg == WORD_W'(PEAKS - 1));
    timeout_evt = timer_hit &&
                  ((wait_st && start && !maximas_found_active) ||
                   (stream_st && !frame_done));
  end

  // Writes during STREAM are issued even when the FIFO is full; the FIFO
  // discards them and the frame still counts.
  assign piso_load  = hdr_write;
  assign fifo_winc  = hdr_write || (stream_st && piso_output_active);
  assign fifo_wdata = hdr_write ? HEADER_WORD :
                      stream_st ? piso_serial_out : '0;
  assign core_reset = core_reset_reg;
  assign busy       = busy_reg;

  // State, registered decodes, word counter and timeout timer. The timer is
  // cleared on every transition so each state visit starts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      core_reset_reg <= 1'b1;
      busy_reg       <= 1'b0;
      word_cnt_reg   <= '0;
      timer_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            state_reg <= REARM;
            busy_reg  <= 1'b1;
          end
        end
        REARM: begin
          state_reg      <= WAIT_PEAKS;
          core_reset_reg <= 1'b0;
          timer_reg      <= '0;
        end
        WAIT_PEAKS: begin
          if (!start) begin
            state_reg      <= IDLE;
            core_reset_reg <= 1'b1;
            busy_reg       <= 1'b0;
            timer_reg      <= '0;
          end else if (hdr_write) begin
            state_reg    <= STREAM;
            word_cnt_reg <= '0;
            timer_reg    <= '0;
          end else if (drop_evt || timeout_evt) begin
            state_reg      <= REARM;
            core_reset_reg <= 1'b1;
            timer_reg      <= '0;
          end else begin
            timer_reg <= timer_reg + TIMER_W'(1);
          end
        end
        STREAM: begin
          // start is only looked at once the frame is finished or abandoned.
          if (frame_done || timeout_evt) begin
            state_reg      <= start ? REARM : IDLE;
            core_reset_reg <= 1'b1;
            busy_reg       <= start;
            timer_reg      <= '0;
          end else begin
            timer_reg <= timer_reg + TIMER_W'(1);
            if (piso_output_active) begin
              word_cnt_reg <= word_cnt_reg + WORD_W'(1);
            end
          end
        end
        default: begin
          state_reg      <= IDLE;
          core_reset_reg <= 1'b1;
          busy_reg       <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.WIDTH(16)) u_frame_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (frame_done),
    .count (frame_count)
  );

  sat_counter #(.WIDTH(8)) u_drop_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (drop_evt),
    .count (drop_count)
  );

  sat_counter #(.WIDTH(8)) u_timeout_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (timeout_evt),
    .count (timeout_count)
  );

endmodule

// File: tb/tb_frame_scheduler.sv
// Self-checking bench for frame_scheduler (TIMEOUT_CYCLES reduced to 100).
module tb_frame_scheduler;

  localparam int         PEAKS = 16;
  localparam int         DSIZE = 9;
  localparam int         TO    = 100;
  localparam logic [8:0] HDR   = 9'h1FF;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             maximas = 1'b0;
  logic [DSIZE-1:0] piso_data = '0;
  logic             piso_active = 1'b0;
  logic             fifo_full = 1'b0;
  logic             core_reset, piso_load, fifo_winc, busy;
  logic [DSIZE-1:0] fifo_wdata;
  logic [15:0]      frame_count;
  logic [7:0]       drop_count, timeout_count;

  frame_scheduler #(
    .PEAKS(PEAKS), .DSIZE(DSIZE), .TIMEOUT_CYCLES(TO), .HEADER_WORD(HDR)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .maximas_found_active (maximas),
    .piso_serial_out      (piso_data),
    .piso_output_active   (piso_active),
    .fifo_full            (fifo_full),
    .core_reset           (core_reset),
    .piso_load            (piso_load),
    .fifo_winc            (fifo_winc),
    .fifo_wdata           (fifo_wdata),
    .busy                 (busy),
    .frame_count          (frame_count),
    .drop_count           (drop_count),
    .timeout_count        (timeout_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int load_cnt = 0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];

  // Monitor: record every FIFO write and PISO load, away from the edge.
  always @(negedge clk) begin
    if (fifo_winc) got_q.push_back(fifo_wdata);
    if (piso_load) load_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; maximas = 1'b0;
    piso_active = 1'b0; fifo_full = 1'b0; piso_data = '0;
    tick(); tick();
    reset = 1'b0;
    got_q.delete(); exp_q.delete(); load_cnt = 0;
  endtask

  // Raise start and wait (bounded) for the core to be released.
  task automatic arm(input string name);
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (core_reset == 1'b0) return;
    end
    check(name, core_reset, 0);
  endtask

  task automatic pulse(input logic full);
    fifo_full = full; maximas = 1'b1;
    tick();
    maximas = 1'b0; fifo_full = 1'b0;
  endtask

  // Feed n PISO words with up to gap_max idle cycles before each one.
  task automatic stream_words(input int n, input int gap_max, input int drop_start_after, input bit rnd);
    for (int w = 1; w <= n; w++) begin
      int gaps;
      gaps = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
      piso_active = 1'b0;
      repeat (gaps) tick();
      piso_data   = rnd ? 9'($urandom) : 9'(w);
      fifo_full   = rnd ? 1'($urandom_range(1, 0)) : 1'b0;
      piso_active = 1'b1;
      exp_q.push_back(piso_data);
      tick();
      piso_active = 1'b0; fifo_full = 1'b0;
      if (w == drop_start_after) start = 1'b0;
    end
  endtask

  task automatic compare_queues(input string name);
    int n;
    check({name, "_len"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({name, "_word"}, got_q[i], exp_q[i]);
  endtask

  typedef struct {
    string      name;
    logic       st;
    logic       maxf;
    logic       full;
    logic       exp_load;
    logic       exp_winc;
    logic [8:0] exp_wdata;
    logic       exp_core_reset;
    logic       exp_busy;
    logic [7:0] exp_drop;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int cyc, ef, ed;
    logic full;

    vecs[0] = '{"v_load",    1'b1, 1'b1, 1'b0, 1'b1, 1'b1, HDR,  1'b0, 1'b1, 8'd0};
    vecs[1] = '{"v_drop",    1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 9'd0, 1'b1, 1'b1, 8'd1};
    vecs[2] = '{"v_wait",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 1'b0, 1'b1, 8'd0};
    vecs[3] = '{"v_stop",    1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 1'b1, 1'b0, 8'd0};
    vecs[4] = '{"v_stopful", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 1'b1, 1'b0, 8'd0};

    // Reset state
    do_reset();
    check("rst_core_reset", core_reset, 1);
    check("rst_piso_load", piso_load, 0);
    check("rst_fifo_winc", fifo_winc, 0);
    check("rst_fifo_wdata", fifo_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_frame", frame_count, 0);
    check("rst_drop", drop_count, 0);
    check("rst_timeout", timeout_count, 0);

    // Table: single WAIT_PEAKS decisions
    for (int i = 0; i < 5; i++) begin
      do_reset();
      arm({vecs[i].name, "_arm"});
      start = vecs[i].st; maximas = vecs[i].maxf; fifo_full = vecs[i].full;
      #1;
      check({vecs[i].name, "_load"}, piso_load, vecs[i].exp_load);
      check({vecs[i].name, "_winc"}, fifo_winc, vecs[i].exp_winc);
      check({vecs[i].name, "_wdata"}, fifo_wdata, vecs[i].exp_wdata);
      tick();
      maximas = 1'b0; fifo_full = 1'b0;
      check({vecs[i].name, "_core_reset"}, core_reset, vecs[i].exp_core_reset);
      check({vecs[i].name, "_busy"}, busy, vecs[i].exp_busy);
      check({vecs[i].name, "_drop"}, drop_count, vecs[i].exp_drop);
    end

    // Normal frame with start-to-release latency and rearm pulse width
    do_reset();
    start = 1'b1;
    tick();
    check("b_rearm_core_reset", core_reset, 1);
    check("b_rearm_busy", busy, 1);
    tick();
    check("b_release", core_reset, 0);
    exp_q.push_back(HDR);
    pulse(1'b0);
    stream_words(PEAKS, 1, 0, 1'b0);
    check("b_rearm_after_frame", core_reset, 1);
    check("b_frame_count", frame_count, 1);
    tick();
    check("b_rearm_one_cycle", core_reset, 0);
    check("b_load_cnt", load_cnt, 1);
    compare_queues("b_fifo");

    // Timeout in WAIT_PEAKS, then a stalled PISO timeout in STREAM
    do_reset();
    start = 1'b1;
    tick(); tick();
    cyc = 1;
    while (timeout_count == 0 && cyc < 300) begin
      tick();
      cyc++;
    end
    check("c_wait_timeout_cycle", cyc, TO + 1);
    check("c_wait_timeout_count", timeout_count, 1);
    check("c_wait_rearm", core_reset, 1);
    check("c_wait_no_writes", got_q.size(), 0);
    arm("c_arm2");
    exp_q.push_back(HDR);
    pulse(1'b0);
    stream_words(5, 0, 0, 1'b0);
    cyc = 0;
    while (timeout_count < 2 && cyc < 300) begin
      tick();
      cyc++;
    end
    check("c_stream_timeout_count", timeout_count, 2);
    check("c_stream_frame_count", frame_count, 0);
    check("c_stream_rearm", core_reset, 1);
    compare_queues("c_fifo");

    // start dropped after word 8: frame completes, then IDLE
    do_reset();
    arm("d_arm");
    exp_q.push_back(HDR);
    pulse(1'b0);
    stream_words(PEAKS, 0, 8, 1'b0);
    check("d_idle_core_reset", core_reset, 1);
    check("d_idle_busy", busy, 0);
    check("d_frame_count", frame_count, 1);
    tick(); tick();
    check("d_stays_idle", busy, 0);
    compare_queues("d_fifo");

    // 256 drops: drop_count saturates at 255
    do_reset();
    for (int k = 0; k < 256; k++) begin
      arm("e_arm");
      pulse(1'b1);
      if (k == 254) check("e_drop_255", drop_count, 255);
    end
    check("e_drop_sat", drop_count, 255);
    check("e_no_writes", got_q.size(), 0);
    check("e_no_loads", load_cnt, 0);

    // Reset in the middle of STREAM
    do_reset();
    arm("f_arm1");
    pulse(1'b1);
    arm("f_arm2");
    pulse(1'b0);
    stream_words(5, 0, 0, 1'b0);
    check("f_pre_drop", drop_count, 1);
    piso_active = 1'b1; piso_data = 9'h055; reset = 1'b1;
    tick();
    check("f_core_reset", core_reset, 1);
    check("f_piso_load", piso_load, 0);
    check("f_fifo_winc", fifo_winc, 0);
    check("f_fifo_wdata", fifo_wdata, 0);
    check("f_busy", busy, 0);
    check("f_drop", drop_count, 0);
    check("f_frame", frame_count, 0);
    reset = 1'b0; piso_active = 1'b0;

    // Randomized frames against a transaction-level model
    do_reset();
    ef = 0; ed = 0;
    for (int f = 0; f < 30; f++) begin
      arm("g_arm");
      repeat ($urandom_range(20, 0)) tick();
      full = ($urandom_range(3, 0) == 0);
      if (!full) exp_q.push_back(HDR);
      pulse(full);
      if (!full) begin
        stream_words(PEAKS, 3, 0, 1'b1);
        ef++;
      end else begin
        ed++;
      end
    end
    tick();
    compare_queues("g_fifo");
    check("g_frame_count", frame_count, ef);
    check("g_drop_count", drop_count, ed);
    check("g_timeout_count", timeout_count, 0);
    check("g_load_cnt", load_cnt, ef);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
